// File: rtl/fu_alu_issue_ctrl.sv
// Issue controller/arbiter sharing one single-cycle integer ALU among NREQ requesters.
// Optional build macro FU_ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module fu_alu_issue_ctrl #(
    parameter int         NREQ    = 4,
    parameter int         TAG_W   = 4,
    parameter logic [3:0] FU_ID   = 4'd1,
    parameter int         TIMEOUT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_ctrl,
    input  logic [32*NREQ-1:0]    req_a,
    input  logic [32*NREQ-1:0]    req_b,
    input  logic [TAG_W*NREQ-1:0] req_tag,
    output logic                  alu_en,
    output logic [3:0]            alu_ctrl,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_id,
    input  logic [31:0]           alu_res,
    input  logic                  alu_zero,
    input  logic                  alu_ovf,
    input  logic [3:0]            alu_finish,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_res,
    output logic                  out_zero,
    output logic                  out_ovf,
    output logic [TAG_W-1:0]      out_tag,
    output logic [2:0]            out_src,
    output logic                  busy,
    output logic                  err
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WC_W-1:0]   r_wcnt;
    logic [TAG_W-1:0]  r_tag;
    logic [2:0]        r_src;
    logic              r_out_valid;
    logic [31:0]       r_out_res;
    logic              r_out_zero;
    logic              r_out_ovf;
    logic [TAG_W-1:0]  r_out_tag;
    logic [2:0]        r_out_src;
    logic              r_err;
    logic [2:0]        w_win;
    logic              w_issue;
    logic              w_cap;
    logic              w_tmo;

`ifdef FU_ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest asserted index wins.
    always_comb begin : arb_fixed
        logic v_found;
        v_found = 1'b0;
        w_win   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!v_found && req_valid[k]) begin
                w_win   = 3'(k);
                v_found = 1'b1;
            end else begin
                w_win   = w_win;
            end
        end
    end
`else
    logic [2:0] r_last_grant;

    // Round-robin: search starts just after the last accepted requester.
    always_comb begin : arb_rr
        logic v_found;
        int   v_idx;
        v_found = 1'b0;
        v_idx   = 0;
        w_win   = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_last_grant) + k) % NREQ;
            if (!v_found && req_valid[v_idx]) begin
                w_win   = 3'(v_idx);
                v_found = 1'b1;
            end else begin
                w_win   = w_win;
            end
        end
    end

    // Last-grant pointer moves only on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 3'(NREQ - 1);
        end else if (w_issue) begin
            r_last_grant <= w_win;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and issue/capture/timeout decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_cap       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            FLUSH: w_state_nxt = IDLE;
            IDLE: begin
                if ((|req_valid) && (!r_out_valid || out_ready)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (alu_finish == FU_ID) begin
                    w_cap       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wcnt == WC_W'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = FLUSH;
        endcase
    end

    // In-flight bookkeeping, output register and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt      <= '0;
            r_tag       <= '0;
            r_src       <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_res   <= 32'd0;
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_tag   <= '0;
            r_out_src   <= 3'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tag  <= req_tag[int'(w_win)*TAG_W +: TAG_W];
                r_src  <= w_win;
                r_wcnt <= '0;
            end else if (r_state == WAIT && !w_cap && !w_tmo) begin
                r_wcnt <= r_wcnt + WC_W'(1);
            end else begin
                r_wcnt <= r_wcnt;
            end
            // Capture wins over a same-cycle consume.
            if (w_cap) begin
                r_out_valid <= 1'b1;
                r_out_res   <= alu_res;
                r_out_zero  <= alu_zero;
                r_out_ovf   <= alu_ovf;
                r_out_tag   <= r_tag;
                r_out_src   <= r_src;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign req_ready = w_issue ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
    assign alu_en    = w_issue;
    assign alu_ctrl  = w_issue ? req_ctrl[int'(w_win)*4 +: 4]   : 4'd0;
    assign alu_a     = w_issue ? req_a[int'(w_win)*32 +: 32]    : 32'd0;
    assign alu_b     = w_issue ? req_b[int'(w_win)*32 +: 32]    : 32'd0;
    assign alu_id    = FU_ID;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_zero  = r_out_zero;
    assign out_ovf   = r_out_ovf;
    assign out_tag   = r_out_tag;
    assign out_src   = r_out_src;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_fu_alu_issue_ctrl.sv
// Directed self-checking bench for fu_alu_issue_ctrl with a small single-cycle ALU model.
module tb_fu_alu_issue_ctrl;

    localparam int NREQ = 4;
    localparam int TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [4*NREQ-1:0]     req_ctrl;
    logic [32*NREQ-1:0]    req_a;
    logic [32*NREQ-1:0]    req_b;
    logic [TAG_W*NREQ-1:0] req_tag;
    logic                  alu_en;
    logic [3:0]            alu_ctrl;
    logic [31:0]           alu_a, alu_b;
    logic [3:0]            alu_id;
    logic [31:0]           alu_res;
    logic                  alu_zero, alu_ovf;
    logic [3:0]            alu_finish;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_res;
    logic                  out_zero, out_ovf;
    logic [TAG_W-1:0]      out_tag;
    logic [2:0]            out_src;
    logic                  busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    fu_alu_issue_ctrl #(.NREQ(NREQ), .TAG_W(TAG_W), .FU_ID(4'd1), .TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_en(alu_en), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_id(alu_id),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_finish(alu_finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_tag(out_tag), .out_src(out_src),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // ALU model: latches on EN, reports finish the following cycle; ctrl 0 = ADD, else SUB.
    logic        m_pend = 1'b0;
    logic        model_on = 1'b1;
    logic [3:0]  m_ctrl = 4'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    always @(posedge clk) begin
        m_pend <= alu_en & model_on;
        if (alu_en) begin
            m_ctrl <= alu_ctrl;
            m_a    <= alu_a;
            m_b    <= alu_b;
        end
    end
    assign alu_finish = m_pend ? 4'd1 : 4'd0;
    assign alu_res    = (m_ctrl == 4'd0) ? (m_a + m_b) : (m_a - m_b);
    assign alu_zero   = (alu_res == 32'd0);
    assign alu_ovf    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_grant(input int k);
`ifdef FU_ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return k % NREQ;
`endif
    endfunction

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        req_valid = '1; req_ctrl = '0; req_a = '0; req_b = '0; req_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'(100 + i);
            req_b[32*i +: 32] = 32'(i);
            req_tag[TAG_W*i +: TAG_W] = TAG_W'(i + 4);
        end
        tick(); tick();
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_alu_en", 64'(alu_en), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("flush_alu_en", 64'(alu_en), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("first_grant", 64'(req_ready), 64'd1);
        chk("first_alu_en", 64'(alu_en), 64'd1);
        chk("first_alu_a", 64'(alu_a), 64'd100);
        chk("alu_id", 64'(alu_id), 64'd1);
        tick();
        chk("wait_alu_en", 64'(alu_en), 64'd0);
        chk("wait_req_ready", 64'(req_ready), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);

        // Sustained issue every 2 cycles.
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << exp_grant(k)));
            chk("rr_prev_src", 64'(out_src), 64'(exp_grant(k - 1)));
            chk("rr_prev_res", 64'(out_res), 64'(100 + 2 * exp_grant(k - 1)));
            chk("rr_prev_tag", 64'(out_tag), 64'(exp_grant(k - 1) + 4));
            tick();
            chk("rr_gap", 64'(req_ready), 64'd0);
        end
        req_valid = '0;
        tick(); tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Single ADD from requester 2.
        req_ctrl[8 +: 4] = 4'd0; req_a[64 +: 32] = 32'd7; req_b[64 +: 32] = 32'd5;
        req_tag[8 +: 4] = 4'd9; req_valid = 4'b0100;
        #1;
        chk("single_grant", 64'(req_ready), 64'b0100);
        chk("single_alu_a", 64'(alu_a), 64'd7);
        chk("single_alu_b", 64'(alu_b), 64'd5);
        tick();
        req_valid = '0;
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_res", 64'(out_res), 64'd12);
        chk("single_tag", 64'(out_tag), 64'd9);
        chk("single_src", 64'(out_src), 64'd2);
        chk("single_zero", 64'(out_zero), 64'd0);

        // Back-pressure: result held, issue stalled.
        out_ready = 1'b0; req_valid = 4'b1111;
        #1;
        chk("bp_ready0", 64'(req_ready), 64'd0);
        chk("bp_en0", 64'(alu_en), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_res", 64'(out_res), 64'd12);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
`ifdef FU_ALU_ARB_FIXED_PRIO_EN
        chk("bp_release_grant", 64'(req_ready), 64'b0001);
`else
        chk("bp_release_grant", 64'(req_ready), 64'b1000);
`endif
        chk("bp_release_en", 64'(alu_en), 64'd1);
        tick();
        req_valid = '0;
        chk("bp_consumed", 64'(out_valid), 64'd0);
        tick(); tick(); tick();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Timeout: ALU never finishes.
        model_on = 1'b0; req_valid = 4'b0001;
        #1;
        chk("to_issue", 64'(alu_en), 64'd1);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            chk("to_err_pending", 64'(err), 64'd0);
            chk("to_busy", 64'(busy), 64'd1);
            tick();
        end
        chk("to_err", 64'(err), 64'd1);
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_no_result", 64'(out_valid), 64'd0);
        tick();
        chk("to_err_sticky", 64'(err), 64'd1);

        // Reset during WAIT discards the in-flight op.
        model_on = 1'b1; req_valid = 4'b0001;
        #1;
        chk("rw_issue", 64'(alu_en), 64'd1);
        tick();
        req_valid = '0;
        chk("rw_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("rw_out_valid", 64'(out_valid), 64'd0);
        chk("rw_out_res", 64'(out_res), 64'd0);
        chk("rw_err", 64'(err), 64'd0);
        chk("rw_alu_en", 64'(alu_en), 64'd0);
        chk("rw_busy_flush", 64'(busy), 64'd1);
        rst_n = 1'b1;
        tick(); tick();
        chk("rw_no_result", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
